id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Pipelined successor to the single-cycle control decoder.
- Decodes the fetched RV32I/E instruction, resolves the branch condition in ID, and detects load-use hazards.
- Registers the full control and operand bundle into an ID/EX pipeline register with a valid/ready handshake.
- Sits between the fetch stage and EX. The register file is read combinationally by address. reg1_rdata/reg2_rdata arrive already forwarded.

Parameters:
- XLEN, 32, data/PC width.
- REG_ADDR_WIDTH, 5, register address width.
- RVE, 0, 1 = only x0..x15 legal; any rd/rs1/rs2 used with bit 4 set is illegal.
- LOAD_USE_STALL, 1, 1 = interlock on load-use; 0 = no interlock (EX forwards from MEM).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  ID accepts this cycle
- if_inst  in  32  instruction
- if_pc  in  XLEN  instruction PC
- reg1_raddr  out  REG_ADDR_WIDTH  rs1 address (combinational from if_inst; 0 if unused)
- reg2_raddr  out  REG_ADDR_WIDTH  rs2 address (combinational from if_inst; 0 if unused)
- reg1_rdata  in  XLEN  forwarded rs1 value
- reg2_rdata  in  XLEN  forwarded rs2 value
- flush  in  1  kill ID/EX contents and the incoming instruction
- ex_ready  in  1  EX accepts ID/EX contents
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_pc  out  XLEN  registered PC
- ex_inst  out  32  registered instruction (for immediate generation in EX)
- ex_rs1_data  out  XLEN  registered rs1 operand
- ex_rs2_data  out  XLEN  registered rs2 operand
- ex_rd  out  REG_ADDR_WIDTH  destination register
- ex_reg_wen  out  1  register write enable
- ex_imm_gen_op  out  IMM_GEN_OP_WIDTH  immediate format
- ex_alu_op  out  ALU_OP_WIDTH  ALU opcode
- ex_alu_src_sel  out  ALU_SRC_WIDTH  ALU source select
- ex_mem_ren  out  1  load
- ex_mem_wen  out  1  store
- ex_funct3  out  3  memory size / branch type
- ex_branch  out  1  conditional branch
- ex_branch_taken  out  1  branch condition true
- ex_jump  out  1  JAL/JALR
- ex_illegal  out  1  illegal instruction

Behaviour:
- Reset (async, rst_n=0): ex_valid=0; every ex_* payload output = 0. Release is synchronous to clk. No instruction is accepted in the first cycle after release unless if_valid=1.
- Decode, combinational, per opcode:
  - R/I-ALU: same alu_op mapping as today. funct7[5]=1 selects SUB/SRA. ADD requires funct7=0.
  - LOAD: ALU_ADD, ALU_SRC_IMM, IMM_GEN_I, mem_ren=1, reg_wen=1.
  - STORE: ALU_ADD, ALU_SRC_IMM, IMM_GEN_S, mem_wen=1, reg_wen=0.
  - B: IMM_GEN_B, branch=1.
    - taken: BEQ eq; BNE !eq; BLT signed lt; BGE signed ge; BLTU unsigned lt; BGEU unsigned ge.
    - funct3 010/011 is illegal.
  - JAL: jump=1, ALU_SRC_FOUR_PC, IMM_GEN_J, reg_wen=1.
  - JALR: jump=1, ALU_SRC_FOUR_PC, IMM_GEN_I, reg1 used. funct3≠000 is illegal.
  - LUI: x0+imm, IMM_GEN_U.
  - AUIPC: new define ALU_SRC_PC_IMM, IMM_GEN_U.
  - Any other opcode, or an RVE violation: illegal=1, reg_wen=mem_wen=mem_ren=branch=jump=0.
- Write-enable rule: reg_wen forced 0 when rd=0.
- Hazard: ex_valid & ex_mem_ren & ex_rd≠0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)). Gated by LOAD_USE_STALL.
- Handshake:
  - adv = !ex_valid | ex_ready.
  - if_ready = adv & !hazard & !flush.
  - Transfer occurs when if_valid & if_ready.
- ID/EX register update, at each posedge in this priority:
  1. flush: ex_valid←0 (payload don't-care).
  2. else if adv & transfer: load the decoded bundle, ex_valid←1.
  3. else if adv: ex_valid←0 (bubble; inserted once per hazard cycle).
  4. else: hold all outputs bit-stable.
- Latency: exactly 1 cycle from accept to ex_valid.
- Hazard persistence: the hazard persists while the load sits in EX with ex_ready=0. At most one bubble is inserted once the load advances.
- Illegal instructions are accepted and passed with ex_illegal=1.

Test Plan:
- addi x1,x0,5 (0x00500093), ex_ready=1 → next cycle:
  - ex_valid=1, ex_rd=1, ex_reg_wen=1
  - ex_alu_op=ALU_ADD, ex_alu_src_sel=ALU_SRC_IMM
- lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3) → the cycle after lw is accepted:
  - if_ready=0; next edge ex_valid=0 (bubble)
  - add accepted the following cycle; with LOAD_USE_STALL=0, no bubble.
- beq x1,x2 (0x00208463):
  - rdata 7/7 → ex_branch_taken=1; 7/8 → 0.
  - blt (0x0020C463) with 0xFFFFFFFF/1 → taken=1; bltu (0x0020E463) same data → taken=0.
- ex_ready=0 for 3 cycles with if_valid=1 → if_ready=0; all ex_* outputs unchanged; released on ex_ready=1.
- flush=1 with if_valid=1 → if_ready=0, next ex_valid=0; the instruction is re-presented and accepted the cycle after flush drops.
- Illegal and reset cases:
  - RVE=1, add x16,x0,x0 (0x00000833) → ex_illegal=1, ex_reg_wen=0.
  - 0xFFFFFFFF → ex_illegal=1.
  - rst_n low mid-stall → ex_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I/E instruction decode stage: control decode, branch resolve,
// load-use interlock and the ID/EX pipeline register with a valid/ready handshake.
package id_stage_pkg;
  localparam int ALU_OP_WIDTH     = 4;
  localparam int ALU_SRC_WIDTH    = 2;
  localparam int IMM_GEN_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;

  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_REG     = 2'd0;
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_IMM     = 2'd1;
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_FOUR_PC = 2'd2;
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_PC_IMM  = 2'd3;

  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_NONE = 3'd0;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_I    = 3'd1;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_S    = 3'd2;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_B    = 3'd3;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_U    = 3'd4;
  localparam logic [IMM_GEN_OP_WIDTH-1:0] IMM_GEN_J    = 3'd5;
endpackage

module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit RVE            = 1'b0,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_valid,
  output logic                        if_ready,
  input  logic [31:0]                 if_inst,
  input  logic [XLEN-1:0]             if_pc,
  output logic [REG_ADDR_WIDTH-1:0]   reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0]   reg2_raddr,
  input  logic [XLEN-1:0]             reg1_rdata,
  input  logic [XLEN-1:0]             reg2_rdata,
  input  logic                        flush,
  input  logic                        ex_ready,
  output logic                        ex_valid,
  output logic [XLEN-1:0]             ex_pc,
  output logic [31:0]                 ex_inst,
  output logic [XLEN-1:0]             ex_rs1_data,
  output logic [XLEN-1:0]             ex_rs2_data,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rd,
  output logic                        ex_reg_wen,
  output logic [IMM_GEN_OP_WIDTH-1:0] ex_imm_gen_op,
  output logic [ALU_OP_WIDTH-1:0]     ex_alu_op,
  output logic [ALU_SRC_WIDTH-1:0]    ex_alu_src_sel,
  output logic                        ex_mem_ren,
  output logic                        ex_mem_wen,
  output logic [2:0]                  ex_funct3,
  output logic                        ex_branch,
  output logic                        ex_branch_taken,
  output logic                        ex_jump,
  output logic                        ex_illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;

  assign opcode = if_inst[6:0];
  assign rd_f   = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1_f  = if_inst[19:15];
  assign rs2_f  = if_inst[24:20];
  assign funct7 = if_inst[31:25];

  logic                        rd_used, rs1_used, rs2_used, legal;
  logic                        mem_ren, mem_wen, branch, jump, taken;
  logic [ALU_OP_WIDTH-1:0]     alu_op;
  logic [ALU_SRC_WIDTH-1:0]    alu_src;
  logic [IMM_GEN_OP_WIDTH-1:0] imm_op;
  logic                        eq, lt_s, lt_u;

  assign eq   = reg1_rdata == reg2_rdata;
  assign lt_s = $signed(reg1_rdata) < $signed(reg2_rdata);
  assign lt_u = reg1_rdata < reg2_rdata;

  function automatic logic [ALU_OP_WIDTH-1:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  always_comb begin
    rd_used  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    legal    = 1'b1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    taken    = 1'b0;
    alu_op   = ALU_ADD;
    alu_src  = ALU_SRC_REG;
    imm_op   = IMM_GEN_NONE;
    case (opcode)
      OPC_OP: begin
        rd_used  = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        alu_op   = alu_map(funct3, funct7[5]);
        legal    = (funct7 == 7'b0000000) ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        rd_used  = 1'b1;
        rs1_used = 1'b1;
        alu_src  = ALU_SRC_IMM;
        imm_op   = IMM_GEN_I;
        // Only shifts carry funct7; elsewhere those bits are immediate.
        case (funct3)
          3'b001: begin
            alu_op = ALU_SLL;
            legal  = funct7 == 7'b0000000;
          end
          3'b101: begin
            alu_op = alu_map(funct3, funct7[5]);
            legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: alu_op = alu_map(funct3, 1'b0);
        endcase
      end
      OPC_LOAD: begin
        rd_used  = 1'b1;
        rs1_used = 1'b1;
        alu_src  = ALU_SRC_IMM;
        imm_op   = IMM_GEN_I;
        mem_ren  = 1'b1;
      end
      OPC_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        alu_src  = ALU_SRC_IMM;
        imm_op   = IMM_GEN_S;
        mem_wen  = 1'b1;
      end
      OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm_op   = IMM_GEN_B;
        branch   = 1'b1;
        case (funct3)
          3'b000:  taken = eq;
          3'b001:  taken = !eq;
          3'b100:  taken = lt_s;
          3'b101:  taken = !lt_s;
          3'b110:  taken = lt_u;
          3'b111:  taken = !lt_u;
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        rd_used = 1'b1;
        jump    = 1'b1;
        alu_src = ALU_SRC_FOUR_PC;
        imm_op  = IMM_GEN_J;
      end
      OPC_JALR: begin
        rd_used  = 1'b1;
        rs1_used = 1'b1;
        jump     = 1'b1;
        alu_src  = ALU_SRC_FOUR_PC;
        imm_op   = IMM_GEN_I;
        legal    = funct3 == 3'b000;
      end
      OPC_LUI: begin
        rd_used = 1'b1;
        alu_src = ALU_SRC_IMM;
        imm_op  = IMM_GEN_U;
      end
      OPC_AUIPC: begin
        rd_used = 1'b1;
        alu_src = ALU_SRC_PC_IMM;
        imm_op  = IMM_GEN_U;
      end
      default: legal = 1'b0;
    endcase
    if (RVE && ((rd_used && rd_f[4]) || (rs1_used && rs1_f[4]) || (rs2_used && rs2_f[4])))
      legal = 1'b0;
    // An illegal instruction travels down the pipe with no side effects.
    if (!legal) begin
      rd_used  = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      taken    = 1'b0;
      alu_op   = ALU_ADD;
      alu_src  = ALU_SRC_REG;
      imm_op   = IMM_GEN_NONE;
    end
  end

  logic [REG_ADDR_WIDTH-1:0] rd_dec;
  logic                      reg_wen_dec, hazard, adv, transfer;

  assign reg1_raddr  = rs1_used ? REG_ADDR_WIDTH'(rs1_f) : '0;
  assign reg2_raddr  = rs2_used ? REG_ADDR_WIDTH'(rs2_f) : '0;
  assign rd_dec      = rd_used ? REG_ADDR_WIDTH'(rd_f) : '0;
  assign reg_wen_dec = rd_used && (rd_f != 5'd0);

  assign hazard = LOAD_USE_STALL && ex_valid && ex_mem_ren && (ex_rd != '0) &&
                  ((rs1_used && reg1_raddr == ex_rd) || (rs2_used && reg2_raddr == ex_rd));
  assign adv      = !ex_valid || ex_ready;
  assign if_ready = adv && !hazard && !flush;
  assign transfer = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_pc           <= '0;
      ex_inst         <= '0;
      ex_rs1_data     <= '0;
      ex_rs2_data     <= '0;
      ex_rd           <= '0;
      ex_reg_wen      <= 1'b0;
      ex_imm_gen_op   <= '0;
      ex_alu_op       <= '0;
      ex_alu_src_sel  <= '0;
      ex_mem_ren      <= 1'b0;
      ex_mem_wen      <= 1'b0;
      ex_funct3       <= '0;
      ex_branch       <= 1'b0;
      ex_branch_taken <= 1'b0;
      ex_jump         <= 1'b0;
      ex_illegal      <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv && transfer) begin
      ex_valid        <= 1'b1;
      ex_pc           <= if_pc;
      ex_inst         <= if_inst;
      ex_rs1_data     <= reg1_rdata;
      ex_rs2_data     <= reg2_rdata;
      ex_rd           <= rd_dec;
      ex_reg_wen      <= reg_wen_dec;
      ex_imm_gen_op   <= imm_op;
      ex_alu_op       <= alu_op;
      ex_alu_src_sel  <= alu_src;
      ex_mem_ren      <= mem_ren;
      ex_mem_wen      <= mem_wen;
      ex_funct3       <= funct3;
      ex_branch       <= branch;
      ex_branch_taken <= taken;
      ex_jump         <= jump;
      ex_illegal      <= !legal;
    end else if (adv) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a rule-level reference model.
// Instance a: RVE=0, LOAD_USE_STALL=1; instance b: RVE=1, LOAD_USE_STALL=0; both share inputs.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct packed {
    logic                        valid;
    logic [31:0]                 pc;
    logic [31:0]                 inst;
    logic [31:0]                 rs1;
    logic [31:0]                 rs2;
    logic [4:0]                  rd;
    logic                        wen;
    logic [IMM_GEN_OP_WIDTH-1:0] imm;
    logic [ALU_OP_WIDTH-1:0]     alu;
    logic [ALU_SRC_WIDTH-1:0]    src;
    logic                        mren;
    logic                        mwen;
    logic [2:0]                  f3;
    logic                        br;
    logic                        tk;
    logic                        jmp;
    logic                        ill;
  } bundle_t;

  typedef struct packed {
    bundle_t    b;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] r1a;
    logic [4:0] r2a;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [31:0] if_inst = '0, if_pc = '0, reg1_rdata = '0, reg2_rdata = '0;
  logic        rdy_a, rdy_b;
  logic [4:0]  r1a_a, r2a_a, r1a_b, r2a_b;
  bundle_t     obs_a, obs_b;
  bundle_t     mdl [2];
  logic        rdy_seen [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  id_stage #(.RVE(1'b0), .LOAD_USE_STALL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(rdy_a), .if_inst(if_inst),
    .if_pc(if_pc), .reg1_raddr(r1a_a), .reg2_raddr(r2a_a), .reg1_rdata(reg1_rdata),
    .reg2_rdata(reg2_rdata), .flush(flush), .ex_ready(ex_ready), .ex_valid(obs_a.valid),
    .ex_pc(obs_a.pc), .ex_inst(obs_a.inst), .ex_rs1_data(obs_a.rs1), .ex_rs2_data(obs_a.rs2),
    .ex_rd(obs_a.rd), .ex_reg_wen(obs_a.wen), .ex_imm_gen_op(obs_a.imm), .ex_alu_op(obs_a.alu),
    .ex_alu_src_sel(obs_a.src), .ex_mem_ren(obs_a.mren), .ex_mem_wen(obs_a.mwen),
    .ex_funct3(obs_a.f3), .ex_branch(obs_a.br), .ex_branch_taken(obs_a.tk),
    .ex_jump(obs_a.jmp), .ex_illegal(obs_a.ill)
  );

  id_stage #(.RVE(1'b1), .LOAD_USE_STALL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(rdy_b), .if_inst(if_inst),
    .if_pc(if_pc), .reg1_raddr(r1a_b), .reg2_raddr(r2a_b), .reg1_rdata(reg1_rdata),
    .reg2_rdata(reg2_rdata), .flush(flush), .ex_ready(ex_ready), .ex_valid(obs_b.valid),
    .ex_pc(obs_b.pc), .ex_inst(obs_b.inst), .ex_rs1_data(obs_b.rs1), .ex_rs2_data(obs_b.rs2),
    .ex_rd(obs_b.rd), .ex_reg_wen(obs_b.wen), .ex_imm_gen_op(obs_b.imm), .ex_alu_op(obs_b.alu),
    .ex_alu_src_sel(obs_b.src), .ex_mem_ren(obs_b.mren), .ex_mem_wen(obs_b.mwen),
    .ex_funct3(obs_b.f3), .ex_branch(obs_b.br), .ex_branch_taken(obs_b.tk),
    .ex_jump(obs_b.jmp), .ex_illegal(obs_b.ill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode built from the instruction-set rules, one mnemonic group at a time.
  function automatic dec_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2, input bit rve);
    dec_t                    d;
    logic [ALU_OP_WIDTH-1:0] base [8];
    logic [6:0]              opc, f7;
    logic [2:0]              f3;
    logic [4:0]              rd, s1, s2;
    bit                      ud, u1, u2, ok;
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = inst[6:0]; rd = inst[11:7]; f3 = inst[14:12];
    s1 = inst[19:15]; s2 = inst[24:20]; f7 = inst[31:25];
    d = '0;
    d.b.valid = 1'b1; d.b.pc = pc; d.b.inst = inst; d.b.rs1 = r1; d.b.rs2 = r2; d.b.f3 = f3;
    d.b.alu = ALU_ADD; d.b.src = ALU_SRC_REG; d.b.imm = IMM_GEN_NONE;
    ud = 0; u1 = 0; u2 = 0; ok = 1;
    case (opc)
      7'h33: begin
        ud = 1; u1 = 1; u2 = 1;
        d.b.alu = base[f3];
        if (f7 == 7'h20) d.b.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        ud = 1; u1 = 1; d.b.src = ALU_SRC_IMM; d.b.imm = IMM_GEN_I;
        d.b.alu = base[f3];
        if (f3 == 3'd1) ok = f7 == 7'h00;
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) d.b.alu = ALU_SRA;
        end
      end
      7'h03: begin ud = 1; u1 = 1; d.b.src = ALU_SRC_IMM; d.b.imm = IMM_GEN_I; d.b.mren = 1; end
      7'h23: begin u1 = 1; u2 = 1; d.b.src = ALU_SRC_IMM; d.b.imm = IMM_GEN_S; d.b.mwen = 1; end
      7'h63: begin
        u1 = 1; u2 = 1; d.b.imm = IMM_GEN_B; d.b.br = 1;
        case (f3)
          3'd0: d.b.tk = (r1 == r2);
          3'd1: d.b.tk = (r1 != r2);
          3'd4: d.b.tk = (int'(r1) < int'(r2));
          3'd5: d.b.tk = (int'(r1) >= int'(r2));
          3'd6: d.b.tk = (longint'(r1) < longint'(r2));
          3'd7: d.b.tk = (longint'(r1) >= longint'(r2));
          default: ok = 0;
        endcase
      end
      7'h6f: begin ud = 1; d.b.jmp = 1; d.b.src = ALU_SRC_FOUR_PC; d.b.imm = IMM_GEN_J; end
      7'h67: begin
        ud = 1; u1 = 1; d.b.jmp = 1; d.b.src = ALU_SRC_FOUR_PC; d.b.imm = IMM_GEN_I;
        ok = f3 == 3'd0;
      end
      7'h37: begin ud = 1; d.b.src = ALU_SRC_IMM; d.b.imm = IMM_GEN_U; end
      7'h17: begin ud = 1; d.b.src = ALU_SRC_PC_IMM; d.b.imm = IMM_GEN_U; end
      default: ok = 0;
    endcase
    if (rve && ((ud && rd >= 16) || (u1 && s1 >= 16) || (u2 && s2 >= 16))) ok = 0;
    if (!ok) begin
      ud = 0; u1 = 0; u2 = 0;
      d.b.mren = 0; d.b.mwen = 0; d.b.br = 0; d.b.tk = 0; d.b.jmp = 0; d.b.ill = 1;
      d.b.alu = ALU_ADD; d.b.src = ALU_SRC_REG; d.b.imm = IMM_GEN_NONE;
    end
    d.rs1u = u1; d.rs2u = u2;
    d.r1a = u1 ? s1 : 5'd0;
    d.r2a = u2 ? s2 : 5'd0;
    d.b.rd  = ud ? rd : 5'd0;
    d.b.wen = ud && rd != 5'd0;
    return d;
  endfunction

  task automatic cmp(input int k);
    bundle_t o, e;
    string   n;
    o = (k == 0) ? obs_a : obs_b;
    e = mdl[k];
    n = (k == 0) ? "a" : "b";
    check({n, ".ex_valid"}, o.valid, e.valid);
    if (e.valid) begin
      check({n, ".ex_pc"}, o.pc, e.pc);
      check({n, ".ex_inst"}, o.inst, e.inst);
      check({n, ".ex_rs1_data"}, o.rs1, e.rs1);
      check({n, ".ex_rs2_data"}, o.rs2, e.rs2);
      check({n, ".ex_rd"}, o.rd, e.rd);
      check({n, ".ex_reg_wen"}, o.wen, e.wen);
      check({n, ".ex_imm_gen_op"}, o.imm, e.imm);
      check({n, ".ex_alu_op"}, o.alu, e.alu);
      check({n, ".ex_alu_src_sel"}, o.src, e.src);
      check({n, ".ex_mem_ren"}, o.mren, e.mren);
      check({n, ".ex_mem_wen"}, o.mwen, e.mwen);
      check({n, ".ex_funct3"}, o.f3, e.f3);
      check({n, ".ex_branch"}, o.br, e.br);
      check({n, ".ex_branch_taken"}, o.tk, e.tk);
      check({n, ".ex_jump"}, o.jmp, e.jmp);
      check({n, ".ex_illegal"}, o.ill, e.ill);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, predict and check the ID/EX register.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input logic fl, input logic er);
    bundle_t nxt [2];
    dec_t    d;
    logic    hz, adv, rdy;
    @(negedge clk);
    if_valid = v; if_inst = inst; if_pc = pc;
    reg1_rdata = r1; reg2_rdata = r2; flush = fl; ex_ready = er;
    #1;
    for (int k = 0; k < 2; k++) begin
      d   = ref_decode(inst, pc, r1, r2, k == 1);
      hz  = (k == 0) && mdl[k].valid && mdl[k].mren && (mdl[k].rd != 5'd0) &&
            ((d.rs1u && d.r1a == mdl[k].rd) || (d.rs2u && d.r2a == mdl[k].rd));
      adv = !mdl[k].valid || er;
      rdy = adv && !hz && !fl;
      rdy_seen[k] = (k == 0) ? rdy_a : rdy_b;
      check($sformatf("%0d.if_ready", k), rdy_seen[k], rdy);
      check($sformatf("%0d.reg1_raddr", k), (k == 0) ? r1a_a : r1a_b, d.r1a);
      check($sformatf("%0d.reg2_raddr", k), (k == 0) ? r2a_a : r2a_b, d.r2a);
      nxt[k] = mdl[k];
      if (fl) nxt[k].valid = 1'b0;
      else if (adv) begin
        if (v && rdy) nxt[k] = d.b;
        else nxt[k].valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mdl[k] = nxt[k];
      cmp(k);
    end
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [6:0] pick_f7();
    int r;
    r = $urandom_range(0, 5);
    if (r < 3) return 7'h00;
    if (r < 5) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  opcs [9];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    i = $urandom;
    if ($urandom_range(0, 11) == 0) return i;
    i[6:0]   = opcs[$urandom_range(0, 8)];
    i[11:7]  = rand_reg();
    i[19:15] = rand_reg();
    i[24:20] = rand_reg();
    if (i[6:0] == 7'h33) i[31:25] = pick_f7();
    if (i[6:0] == 7'h13 && i[13:12] == 2'b01) i[31:25] = pick_f7();
    if (i[6:0] == 7'h67 && $urandom_range(0, 3) != 0) i[14:12] = 3'd0;
    return i;
  endfunction

  initial begin
    bundle_t     snap;
    logic [31:0] cur, pc, r1, r2;
    logic        v;
    mdl[0] = '0;
    mdl[1] = '0;
    #1;
    check("rst_a_payload", 32'(|obs_a), 32'd0);
    check("rst_b_payload", 32'(|obs_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5
    step(1, 32'h00500093, 32'h100, 32'h11, 32'h22, 0, 1);
    check("addi_valid", obs_a.valid, 1);
    check("addi_rd", obs_a.rd, 1);
    check("addi_wen", obs_a.wen, 1);
    check("addi_alu", obs_a.alu, ALU_ADD);
    check("addi_src", obs_a.src, ALU_SRC_IMM);

    // lw x2,0(x1) then add x3,x2,x2: a stalls one cycle, b has no interlock
    step(1, 32'h0000A103, 32'h104, 32'h5, 32'h0, 0, 1);
    step(1, 32'h002101B3, 32'h108, 32'h3, 32'h3, 0, 1);
    check("lu_ready_a", rdy_seen[0], 0);
    check("lu_bubble_a", obs_a.valid, 0);
    check("lu_ready_b", rdy_seen[1], 1);
    check("lu_rd_b", obs_b.rd, 3);
    step(1, 32'h002101B3, 32'h108, 32'h3, 32'h3, 0, 1);
    check("lu_accept_a", obs_a.rd, 3);

    // branch resolution
    step(1, 32'h00208463, 32'h10C, 32'd7, 32'd7, 0, 1);
    check("beq_eq", obs_a.tk, 1);
    step(1, 32'h00208463, 32'h110, 32'd7, 32'd8, 0, 1);
    check("beq_ne", obs_a.tk, 0);
    step(1, 32'h0020C463, 32'h114, 32'hFFFFFFFF, 32'd1, 0, 1);
    check("blt_neg", obs_a.tk, 1);
    step(1, 32'h0020E463, 32'h118, 32'hFFFFFFFF, 32'd1, 0, 1);
    check("bltu_big", obs_a.tk, 0);

    // EX back-pressure for three cycles
    snap = obs_a;
    for (int c = 0; c < 3; c++) begin
      step(1, 32'h00500093, 32'h11C, 32'h9, 32'h9, 0, 0);
      check("stall_ready", rdy_seen[0], 0);
      check("stall_hold", 32'(obs_a == snap), 1);
    end
    step(1, 32'h00500093, 32'h11C, 32'h9, 32'h9, 0, 1);
    check("stall_release", obs_a.pc, 32'h11C);

    // flush kills the incoming instruction; it is re-presented afterwards
    step(1, 32'h00700113, 32'h200, 32'h1, 32'h2, 1, 1);
    check("flush_ready", rdy_seen[0], 0);
    check("flush_valid", obs_a.valid, 0);
    step(1, 32'h00700113, 32'h200, 32'h1, 32'h2, 0, 1);
    check("flush_reissue", obs_a.pc, 32'h200);

    // RVE and unknown-opcode illegals
    step(1, 32'h00000833, 32'h204, 32'h0, 32'h0, 0, 1);
    check("rve_ill_b", obs_b.ill, 1);
    check("rve_wen_b", obs_b.wen, 0);
    check("rve_ill_a", obs_a.ill, 0);
    check("rve_wen_a", obs_a.wen, 1);
    step(1, 32'hFFFFFFFF, 32'h208, 32'h0, 32'h0, 0, 1);
    check("ones_ill_a", obs_a.ill, 1);
    check("ones_ill_b", obs_b.ill, 1);

    // asynchronous reset in the middle of a stall
    step(1, 32'h0000A103, 32'h20C, 32'h0, 32'h0, 0, 1);
    step(1, 32'h002101B3, 32'h210, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid_a", obs_a.valid, 0);
    check("arst_payload_a", 32'(|obs_a), 32'd0);
    check("arst_payload_b", 32'(|obs_b), 32'd0);
    mdl[0] = '0;
    mdl[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    cur = rand_inst();
    pc  = 32'h1000;
    for (int c = 0; c < 1500; c++) begin
      v  = $urandom_range(0, 5) != 0;
      r1 = $urandom;
      case ($urandom_range(0, 3))
        0:       r2 = r1;
        1:       r2 = r1 ^ 32'h80000000;
        default: r2 = $urandom;
      endcase
      step(v, cur, pc, r1, r2, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      if (v && rdy_seen[0]) begin
        cur = rand_inst();
        pc  = pc + 32'd4;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
